// File: rtl/sfp_pkg.sv
// Shared FSM state type and width helpers for the per-row softmax-style normaliser.
package sfp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    function automatic int den_w(input int bw_sum, input int sum_shift);
        return bw_sum + 1 - sum_shift;
    endfunction

    function automatic int grp_w(input int col, input int lanes_par);
        return (col / lanes_par > 1) ? $clog2(col / lanes_par) : 1;
    endfunction

    function automatic int bit_w(input int bw_psum);
        return (bw_psum > 1) ? $clog2(bw_psum) : 1;
    endfunction

endpackage

// File: rtl/sfp_div_lane.sv
// Restoring divider, one quotient bit per cycle; the first bit is resolved on the start edge
// so a BW_PSUM-bit quotient is ready BW_PSUM edges after start.
module sfp_div_lane #(
    parameter int BW_PSUM = 20,
    parameter int DEN_W   = 18,
    parameter int BIT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BW_PSUM-1:0] numerator,
    input  logic [DEN_W-1:0]   den,
    output logic [BW_PSUM-1:0] quotient,
    output logic               done
);

    localparam logic [BIT_W-1:0] LAST = BIT_W'(BW_PSUM - 1);

    logic [BW_PSUM-1:0] num_q;
    logic [BW_PSUM-1:0] quo_q;
    logic [DEN_W-1:0]   rem_q;
    logic [DEN_W-1:0]   den_q;
    logic [BIT_W-1:0]   cnt;
    logic               active;

    logic [BW_PSUM-1:0] src_num;
    logic [BW_PSUM-1:0] src_quo;
    logic [DEN_W-1:0]   src_rem;
    logic [DEN_W-1:0]   src_den;
    logic [DEN_W:0]     trial;
    logic [DEN_W:0]     diff;
    logic               fits;
    logic [DEN_W-1:0]   rem_nxt;
    logic [BW_PSUM-1:0] quo_nxt;
    logic [BW_PSUM-1:0] num_nxt;

    always_comb begin
        src_num = start ? numerator : num_q;
        src_quo = start ? '0 : quo_q;
        src_rem = start ? '0 : rem_q;
        src_den = start ? den : den_q;
        trial   = {src_rem, src_num[BW_PSUM-1]};
        diff    = trial - {1'b0, src_den};
        fits    = (trial >= {1'b0, src_den});
        // remainder stays below den, so the restored value always fits DEN_W bits
        rem_nxt = fits ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
        quo_nxt = {src_quo[BW_PSUM-2:0], fits};
        num_nxt = {src_num[BW_PSUM-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                num_q  <= num_nxt;
                quo_q  <= quo_nxt;
                rem_q  <= rem_nxt;
                den_q  <= den;
                cnt    <= BIT_W'(1);
                active <= 1'b1;
            end else if (active) begin
                num_q <= num_nxt;
                quo_q <= quo_nxt;
                rem_q <= rem_nxt;
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/sfp_norm_row.sv
// Per-row normaliser: captures |psum| per lane, forms the local sum, divides every lane by the
// shared denominator on LANES_PAR time-shared dividers. Option macro: SFP_SIGN_RESTORE_EN.
module sfp_norm_row
    import sfp_pkg::*;
#(
    parameter int COL       = 8,
    parameter int BW_PSUM   = 20,
    parameter int BW_SUM    = 24,
    parameter int SUM_SHIFT = 7,
    parameter int LANES_PAR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc,
    input  logic                     div,
    input  logic [COL*BW_PSUM-1:0]   sfp_in,
    input  logic [BW_SUM-1:0]        sum_in,
    output logic [BW_SUM-1:0]        sum_out,
    output logic                     sum_rdy,
    output logic                     busy,
    output logic [COL*BW_PSUM-1:0]   sfp_out,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int G     = COL / LANES_PAR;
    localparam int HALF  = COL / 2;
    localparam int DEN_W = den_w(BW_SUM, SUM_SHIFT);
    localparam int GRP_W = grp_w(COL, LANES_PAR);
    localparam int BIT_W = bit_w(BW_PSUM);
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(G - 1);

    state_t state, state_nxt;

    logic [BW_PSUM-1:0] abs_in [COL];
    logic [BW_PSUM-1:0] abs_r  [COL];
    logic [BW_SUM-1:0]  part_lo, part_hi;
    logic [BW_SUM-1:0]  part_lo_r, part_hi_r;
    logic               sum_pend;
    logic [BW_SUM-1:0]  sum_in_r;
    logic [DEN_W-1:0]   den_r;
    logic [BW_SUM:0]    den_full;
    logic [DEN_W-1:0]   den_calc;
    logic [GRP_W-1:0]   grp;
    logic [GRP_W-1:0]   num_grp;
    logic               launch;
    logic               acc_ok;
    logic               div_ok;
    logic               lane_start;
    logic               lane_done;

    logic [BW_PSUM-1:0]   lane_num [LANES_PAR];
    logic [BW_PSUM-1:0]   lane_quo [LANES_PAR];
    logic [LANES_PAR-1:0] lane_dn;

`ifdef SFP_SIGN_RESTORE_EN
    logic [COL-1:0] sign_in;
    logic [COL-1:0] sign_r;
`endif

    assign acc_ok = acc && (state == IDLE) && !div;
    assign div_ok = div && sum_rdy && (state == IDLE);

    always_comb begin
        for (int unsigned i = 0; i < COL; i++) begin
            abs_in[i] = sfp_in[i*BW_PSUM + BW_PSUM - 1]
                      ? (~sfp_in[i*BW_PSUM +: BW_PSUM]) + 1'b1
                      : sfp_in[i*BW_PSUM +: BW_PSUM];
        end
    end

`ifdef SFP_SIGN_RESTORE_EN
    always_comb begin
        for (int unsigned i = 0; i < COL; i++) begin
            sign_in[i] = sfp_in[i*BW_PSUM + BW_PSUM - 1];
        end
    end
`endif

    always_comb begin
        part_lo = '0;
        part_hi = '0;
        for (int unsigned i = 0; i < COL; i++) begin
            if (i < HALF) part_lo = part_lo + BW_SUM'(abs_in[i]);
            else          part_hi = part_hi + BW_SUM'(abs_in[i]);
        end
    end

    // den can reach 2^DEN_W only for an out-of-range partner sum; clamp instead of wrapping to 0
    always_comb begin
        den_full = ((({1'b0, sum_out} + {1'b0, sum_in_r}) >> SUM_SHIFT) + 1'b1);
        den_calc = (|den_full[BW_SUM:DEN_W]) ? '1 : den_full[DEN_W-1:0];
    end

    assign lane_done  = &lane_dn;
    assign num_grp    = launch ? grp : grp + 1'b1;
    assign lane_start = (state == DIV) && (launch || (lane_done && grp != LAST_GRP));

    always_comb begin
        for (int unsigned k = 0; k < LANES_PAR; k++) lane_num[k] = '0;
        for (int unsigned i = 0; i < COL; i++) begin
            if (GRP_W'(i / LANES_PAR) == num_grp) lane_num[i % LANES_PAR] = abs_r[i];
        end
    end

    for (genvar k = 0; k < LANES_PAR; k++) begin : g_lane
        sfp_div_lane #(
            .BW_PSUM (BW_PSUM),
            .DEN_W   (DEN_W),
            .BIT_W   (BIT_W)
        ) u_div (
            .clk       (clk),
            .reset     (reset),
            .start     (lane_start),
            .numerator (lane_num[k]),
            .den       (den_r),
            .quotient  (lane_quo[k]),
            .done      (lane_dn[k])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (div_ok) state_nxt = LOAD;
            LOAD: state_nxt = DIV;
            DIV:  if (lane_done && grp == LAST_GRP) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < COL; i++) abs_r[i] <= '0;
`ifdef SFP_SIGN_RESTORE_EN
            sign_r    <= '0;
`endif
            part_lo_r <= '0;
            part_hi_r <= '0;
            sum_pend  <= 1'b0;
            sum_out   <= '0;
            sum_rdy   <= 1'b1;
            sum_in_r  <= '0;
            den_r     <= '0;
            grp       <= '0;
            launch    <= 1'b0;
            sfp_out   <= '0;
        end else begin
            sum_pend <= acc_ok;
            launch   <= (state == LOAD);
            if (acc_ok) begin
                for (int unsigned i = 0; i < COL; i++) abs_r[i] <= abs_in[i];
`ifdef SFP_SIGN_RESTORE_EN
                sign_r <= sign_in;
`endif
                part_lo_r <= part_lo;
                part_hi_r <= part_hi;
                sum_rdy   <= 1'b0;
            end else if (sum_pend) begin
                sum_out <= part_lo_r + part_hi_r;
                sum_rdy <= 1'b1;
            end
            if (div_ok) sum_in_r <= sum_in;
            if (state == LOAD) begin
                den_r <= den_calc;
                grp   <= '0;
            end
            if (state == DIV && lane_done) begin
                for (int unsigned i = 0; i < COL; i++) begin
                    if (GRP_W'(i / LANES_PAR) == grp) begin
`ifdef SFP_SIGN_RESTORE_EN
                        sfp_out[i*BW_PSUM +: BW_PSUM] <= sign_r[i]
                            ? (~lane_quo[i % LANES_PAR]) + 1'b1
                            : lane_quo[i % LANES_PAR];
`else
                        sfp_out[i*BW_PSUM +: BW_PSUM] <= lane_quo[i % LANES_PAR];
`endif
                    end
                end
                if (grp != LAST_GRP) grp <= grp + 1'b1;
            end
        end
    end

endmodule
